// File: rtl/imem_loader_pkg.sv
// Shared types and default widths for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned IMEM_ADDR_W = 8;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned STATE_W     = 3;
  localparam int unsigned HOLD_CNT_W  = 4;
  localparam int unsigned CKSUM_W     = 32;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    HOLD  = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } loader_state_t;

endpackage

// File: rtl/loader_rst_stretch.sv
// Down-counter that stretches a reset: load arms it with cnt_init cycles,
// expire_c flags the final counted cycle so the owner can release on that edge.
module loader_rst_stretch
  import imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [HOLD_CNT_W-1:0] cnt_init,
  output logic                  expire_c
);

  logic [HOLD_CNT_W-1:0] cnt;
  logic                  active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= cnt_init;
      active <= (cnt_init != '0);
    end else if (active) begin
      cnt <= cnt - HOLD_CNT_W'(1);
      if (cnt == HOLD_CNT_W'(1)) active <= 1'b0;
    end
  end

  assign expire_c = active && (cnt == HOLD_CNT_W'(1));

endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction memory while holding the core in reset.
// Optional IMEM_LOADER_CHECKSUM_EN: last beat is a checksum word (sum must be 0).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W   = IMEM_ADDR_W,
  parameter int unsigned DATA_W   = INSTR_W,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic              err_checksum
`endif
);

  localparam int unsigned WC_W  = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [STATE_W-1:0] S_IDLE  = STATE_W'(IDLE);
  localparam logic [STATE_W-1:0] S_LOAD  = STATE_W'(LOAD);
  localparam logic [STATE_W-1:0] S_HOLD  = STATE_W'(HOLD);
  localparam logic [STATE_W-1:0] S_RUN   = STATE_W'(RUN);
  localparam logic [STATE_W-1:0] S_ERROR = STATE_W'(ERROR);

  logic [STATE_W-1:0] state, state_nxt;
  logic               s_ready_nxt, we_nxt, core_rst_n_nxt, busy_nxt, done_nxt, ovf_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [DATA_W-1:0]  wdata_nxt;
  logic [WC_W-1:0]    wc_nxt;
  logic               accept_c, hold_load_c, hold_expire_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [CKSUM_W-1:0] sum_q, sum_nxt, sum_c;
  logic               cks_nxt;
`endif

  loader_rst_stretch u_rst_stretch (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (hold_load_c),
    .cnt_init (HOLD_CNT_W'(RST_HOLD)),
    .expire_c (hold_expire_c)
  );

  // State register plus every registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      s_ready      <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_rst_n   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      word_count   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
      err_checksum <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      s_ready      <= s_ready_nxt;
      imem_we      <= we_nxt;
      imem_addr    <= addr_nxt;
      imem_wdata   <= wdata_nxt;
      core_rst_n   <= core_rst_n_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      err_overflow <= ovf_nxt;
      word_count   <= wc_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= sum_nxt;
      err_checksum <= cks_nxt;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    we_nxt      = 1'b0;
    addr_nxt    = imem_addr;
    wdata_nxt   = imem_wdata;
    wc_nxt      = word_count;
    ovf_nxt     = err_overflow;
    hold_load_c = 1'b0;
    accept_c    = s_valid && s_ready;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_c       = sum_q + CKSUM_W'(s_data);
    sum_nxt     = sum_q;
    cks_nxt     = err_checksum;
`endif

    case (state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          state_nxt = S_LOAD;
          wc_nxt    = '0;
          ovf_nxt   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_nxt   = '0;
          cks_nxt   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (accept_c) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_nxt = sum_c;
          // Checksum word is consumed, never written.
          if (s_last) begin
            if (sum_c != '0) begin
              cks_nxt   = 1'b1;
              state_nxt = S_ERROR;
            end else begin
              state_nxt   = S_HOLD;
              hold_load_c = 1'b1;
            end
          end else
`endif
          if (word_count == WC_W'(DEPTH)) begin
            ovf_nxt   = 1'b1;
            state_nxt = S_ERROR;
          end else begin
            we_nxt    = 1'b1;
            addr_nxt  = word_count[ADDR_W-1:0];
            wdata_nxt = s_data;
            wc_nxt    = word_count + WC_W'(1);
            if (s_last) begin
              state_nxt   = S_HOLD;
              hold_load_c = 1'b1;
            end
          end
        end
      end
      S_HOLD: begin
        if (hold_expire_c) state_nxt = S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase

    s_ready_nxt    = (state_nxt == S_LOAD);
    busy_nxt       = (state_nxt == S_LOAD) || (state_nxt == S_HOLD);
    done_nxt       = (state_nxt == S_RUN);
    core_rst_n_nxt = (state_nxt == S_RUN);
  end

endmodule
